// File: rtl/idma_legalizer_burst_splitter.sv
// Splits one 1D DMA transfer into bursts that never cross the active window.
// The window is one bus beat, the reduced burst window or the full burst window,
// and it is always capped to the hard page limit.
// Ports:
//   clk_i, rst_ni         clock, asynchronous active-low reset
//   req_*                 transfer request (valid/ready, addr, len, options)
//   burst_*               burst stream (valid/ready, addr, len, last)
//   busy_o                a transfer is being split
//   zero_len_err_o        one-cycle pulse after a len==0 request is accepted
//                         (present only with IDMA_BURST_SPLITTER_ZERO_LEN_ERR_EN)
module idma_legalizer_burst_splitter #(
    parameter int unsigned AddrWidth     = 32,
    parameter int unsigned LenWidth      = 32,
    parameter int unsigned OffsetWidth   = 2,
    parameter int unsigned MaxBeatsLog2  = 8,
    parameter int unsigned PageLimitLog2 = 12
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic [AddrWidth-1:0] req_addr_i,
    input  logic [LenWidth-1:0]  req_len_i,
    input  logic                 not_bursting_i,
    input  logic                 reduce_len_i,
    input  logic [2:0]           max_llen_i,
    output logic                 burst_valid_o,
    input  logic                 burst_ready_i,
    output logic [AddrWidth-1:0] burst_addr_o,
    output logic [LenWidth-1:0]  burst_len_o,
    output logic                 burst_last_o,
    output logic                 busy_o
`ifdef IDMA_BURST_SPLITTER_ZERO_LEN_ERR_EN
    ,
    output logic                 zero_len_err_o
`endif
);

    localparam int unsigned PW = PageLimitLog2 + 1;

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_SPLIT = 1'b1;

    logic [0:0]           r_state;
    logic [AddrWidth-1:0] r_addr;
    logic [LenWidth-1:0]  r_len;
    logic                 r_nb;
    logic                 r_rl;
    logic [2:0]           r_llen;

    logic [7:0]           w_win_raw;
    logic [7:0]           w_win;
    logic [PW-1:0]        w_win_size;
    logic [PW-1:0]        w_off;
    logic [PW-1:0]        w_to_pb;
    logic [LenWidth-1:0]  w_to_pb_ext;
    logic [LenWidth-1:0]  w_blen;
    logic                 w_last;
    logic                 w_split;
    logic                 w_fire;
    logic                 w_req_fire;

    // Window log2, derived from the options frozen at acceptance.
    always_comb begin
        if (r_nb) begin
            w_win_raw = 8'(OffsetWidth);
        end else if (r_rl) begin
            w_win_raw = 8'(OffsetWidth) + {5'd0, r_llen};
        end else begin
            w_win_raw = 8'(OffsetWidth + MaxBeatsLog2);
        end
        if (w_win_raw > 8'(PageLimitLog2)) begin
            w_win = 8'(PageLimitLog2);
        end else begin
            w_win = w_win_raw;
        end
    end

    // Distance to the next window boundary: 1 .. 2^W.
    assign w_win_size  = PW'(1) << w_win;
    assign w_off       = {1'b0, r_addr[PageLimitLog2-1:0]} & (w_win_size - PW'(1));
    assign w_to_pb     = w_win_size - w_off;
    assign w_to_pb_ext = LenWidth'(w_to_pb);

    assign w_last     = (r_len <= w_to_pb_ext);
    assign w_blen     = w_last ? r_len : w_to_pb_ext;
    assign w_split    = (r_state == S_SPLIT);
    assign w_fire     = w_split & burst_ready_i;
    assign w_req_fire = req_valid_i & req_ready_o;

    assign req_ready_o   = ~w_split;
    assign burst_valid_o = w_split;
    assign busy_o        = w_split;
    assign burst_addr_o  = w_split ? r_addr : '0;
    assign burst_len_o   = w_split ? w_blen : '0;
    assign burst_last_o  = w_split & w_last;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= S_IDLE;
            r_addr  <= '0;
            r_len   <= '0;
            r_nb    <= 1'b0;
            r_rl    <= 1'b0;
            r_llen  <= '0;
        end else if (w_req_fire && (req_len_i != '0)) begin
            r_state <= S_SPLIT;
            r_addr  <= req_addr_i;
            r_len   <= req_len_i;
            r_nb    <= not_bursting_i;
            r_rl    <= reduce_len_i;
            r_llen  <= max_llen_i;
        end else if (w_fire) begin
            r_addr <= r_addr + AddrWidth'(w_blen);
            r_len  <= r_len - w_blen;
            if (w_last) begin
                r_state <= S_IDLE;
            end
        end
    end

`ifdef IDMA_BURST_SPLITTER_ZERO_LEN_ERR_EN
    logic r_zle;

    // An empty request is consumed in IDLE and only flagged.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_zle <= 1'b0;
        end else begin
            r_zle <= w_req_fire && (req_len_i == '0);
        end
    end

    assign zero_len_err_o = r_zle;
`endif

endmodule

// File: tb/tb_idma_legalizer_burst_splitter.sv
// Directed bench for idma_legalizer_burst_splitter.
// Instance A: OffsetWidth=2; instance B: OffsetWidth=4 (4 KiB capped window).
module tb_idma_legalizer_burst_splitter;

    logic        clk;
    logic        rst_n;
    logic        req_valid_a;
    logic        req_valid_b;
    logic [31:0] req_addr;
    logic [31:0] req_len;
    logic        nb;
    logic        rl;
    logic [2:0]  llen;
    logic        burst_ready;

    logic        a_rdy, a_valid, a_last, a_busy;
    logic [31:0] a_addr, a_len;
    logic        b_rdy, b_valid, b_last, b_busy;
    logic [31:0] b_addr, b_len;
`ifdef IDMA_BURST_SPLITTER_ZERO_LEN_ERR_EN
    logic        a_zle, b_zle;
`endif

    int checks = 0;
    int errors = 0;

    idma_legalizer_burst_splitter #(
        .OffsetWidth(2)
    ) u_dut_a (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .req_valid_i    (req_valid_a),
        .req_ready_o    (a_rdy),
        .req_addr_i     (req_addr),
        .req_len_i      (req_len),
        .not_bursting_i (nb),
        .reduce_len_i   (rl),
        .max_llen_i     (llen),
        .burst_valid_o  (a_valid),
        .burst_ready_i  (burst_ready),
        .burst_addr_o   (a_addr),
        .burst_len_o    (a_len),
        .burst_last_o   (a_last),
        .busy_o         (a_busy)
`ifdef IDMA_BURST_SPLITTER_ZERO_LEN_ERR_EN
        ,
        .zero_len_err_o (a_zle)
`endif
    );

    idma_legalizer_burst_splitter #(
        .OffsetWidth(4)
    ) u_dut_b (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .req_valid_i    (req_valid_b),
        .req_ready_o    (b_rdy),
        .req_addr_i     (req_addr),
        .req_len_i      (req_len),
        .not_bursting_i (nb),
        .reduce_len_i   (rl),
        .max_llen_i     (llen),
        .burst_valid_o  (b_valid),
        .burst_ready_i  (burst_ready),
        .burst_addr_o   (b_addr),
        .burst_len_o    (b_len),
        .burst_last_o   (b_last),
        .busy_o         (b_busy)
`ifdef IDMA_BURST_SPLITTER_ZERO_LEN_ERR_EN
        ,
        .zero_len_err_o (b_zle)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input bit sel, input logic [31:0] addr,
                        input logic [31:0] len, input logic i_nb,
                        input logic i_rl, input logic [2:0] i_llen);
        @(negedge clk);
        req_addr = addr;
        req_len  = len;
        nb       = i_nb;
        rl       = i_rl;
        llen     = i_llen;
        if (sel) req_valid_b = 1'b1;
        else     req_valid_a = 1'b1;
        chk("req_ready_idle", sel ? b_rdy : a_rdy, 32'd1);
        @(posedge clk);
        #1;
        req_valid_a = 1'b0;
        req_valid_b = 1'b0;
    endtask

    // Waits (bounded) for a burst, checks it, lets it be consumed.
    task automatic expect_burst(input string tag, input bit sel,
                                input logic [31:0] ea, input logic [31:0] el,
                                input logic elast);
        int n;
        n = 0;
        @(negedge clk);
        while (!(sel ? b_valid : a_valid) && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_wait"}, n, 0);
        chk({tag, "_valid"}, sel ? b_valid : a_valid, 32'd1);
        chk({tag, "_addr"}, sel ? b_addr : a_addr, ea);
        chk({tag, "_len"}, sel ? b_len : a_len, el);
        chk({tag, "_last"}, sel ? b_last : a_last, {31'd0, elast});
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n       = 1'b1;
        req_valid_a = 1'b0;
        req_valid_b = 1'b0;
        req_addr    = '0;
        req_len     = '0;
        nb          = 1'b0;
        rl          = 1'b0;
        llen        = '0;
        burst_ready = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        chk("rst_req_ready", a_rdy, 32'd1);
        chk("rst_valid", a_valid, 32'd0);
        chk("rst_busy", a_busy, 32'd0);
        chk("rst_addr", a_addr, 32'd0);
        chk("rst_len", a_len, 32'd0);
        chk("rst_last", a_last, 32'd0);
`ifdef IDMA_BURST_SPLITTER_ZERO_LEN_ERR_EN
        chk("rst_zle", a_zle, 32'd0);
`endif
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // 1 KiB window, unaligned start
        send(0, 32'h3F0, 32'h20, 0, 0, 3'd0);
        expect_burst("t1_b0", 0, 32'h3F0, 32'd16, 1'b0);
        expect_burst("t1_b1", 0, 32'h400, 32'd16, 1'b1);
        @(negedge clk);
        chk("t1_idle_busy", a_busy, 32'd0);
        chk("t1_idle_ready", a_rdy, 32'd1);

        // Single-beat window
        send(0, 32'h1, 32'd6, 1, 0, 3'd0);
        expect_burst("t2_b0", 0, 32'h1, 32'd3, 1'b0);
        expect_burst("t2_b1", 0, 32'h4, 32'd3, 1'b1);

        // Reduced 16 B window
        send(0, 32'h8, 32'd40, 0, 1, 3'd2);
        expect_burst("t3_b0", 0, 32'h08, 32'd8, 1'b0);
        expect_burst("t3_b1", 0, 32'h10, 32'd16, 1'b0);
        expect_burst("t3_b2", 0, 32'h20, 32'd16, 1'b1);

        // 4 KiB capped window on the wide-bus instance
        send(1, 32'hFF8, 32'h1010, 0, 0, 3'd0);
        expect_burst("t4_b0", 1, 32'hFF8, 32'd8, 1'b0);
        expect_burst("t4_b1", 1, 32'h1000, 32'h1000, 1'b0);
        expect_burst("t4_b2", 1, 32'h2000, 32'd8, 1'b1);

        // Address wrap
        send(0, 32'hFFFF_FFFC, 32'd8, 0, 0, 3'd0);
        expect_burst("wrap_b0", 0, 32'hFFFF_FFFC, 32'd4, 1'b0);
        expect_burst("wrap_b1", 0, 32'h0, 32'd4, 1'b1);

        // Backpressure for five cycles
        send(0, 32'h3F0, 32'h20, 0, 0, 3'd0);
        @(negedge clk);
        burst_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", a_valid, 32'd1);
            chk("bp_addr", a_addr, 32'h3F0);
            chk("bp_len", a_len, 32'd16);
            chk("bp_last", a_last, 32'd0);
            chk("bp_req_ready", a_rdy, 32'd0);
            @(negedge clk);
        end
        burst_ready = 1'b1;
        chk("bp_held_addr", a_addr, 32'h3F0);
        chk("bp_held_len", a_len, 32'd16);
        @(posedge clk);
        #1;
        expect_burst("bp_b1", 0, 32'h400, 32'd16, 1'b1);

        // Reset after first burst of the reduced-window transfer
        send(0, 32'h8, 32'd40, 0, 1, 3'd2);
        expect_burst("rs_b0", 0, 32'h08, 32'd8, 1'b0);
        #3;
        rst_n = 1'b0;
        #1;
        chk("rs_valid", a_valid, 32'd0);
        chk("rs_busy", a_busy, 32'd0);
        chk("rs_req_ready", a_rdy, 32'd1);
        chk("rs_addr", a_addr, 32'd0);
        chk("rs_len", a_len, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        send(0, 32'h1, 32'd6, 1, 0, 3'd0);
        expect_burst("rs_n_b0", 0, 32'h1, 32'd3, 1'b0);
        expect_burst("rs_n_b1", 0, 32'h4, 32'd3, 1'b1);

        // Zero-length request
        send(0, 32'h100, 32'd0, 0, 0, 3'd0);
        @(negedge clk);
        chk("zl_valid", a_valid, 32'd0);
        chk("zl_busy", a_busy, 32'd0);
`ifdef IDMA_BURST_SPLITTER_ZERO_LEN_ERR_EN
        chk("zl_err_pulse", a_zle, 32'd1);
`endif
        @(negedge clk);
        chk("zl_valid2", a_valid, 32'd0);
        chk("zl_ready2", a_rdy, 32'd1);
`ifdef IDMA_BURST_SPLITTER_ZERO_LEN_ERR_EN
        chk("zl_err_clear", a_zle, 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
